analog_mux_sequencer: RTL



---
 rtl/analog_mux_sequencer_if.sv | 27 ++
 rtl/analog_mux_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/analog_mux_sequencer_if.sv
// Host channel-select handshake for analog_mux_sequencer.
// The host (master) drives the request strobe, off flag and channel index;
// the sequencer (slave) answers with sel_ready.
interface analog_mux_sequencer_if #(
  parameter int unsigned N_CH = 4
);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic            sel_valid;
  logic            sel_ready;
  logic            sel_off;
  logic [CH_W-1:0] sel_ch;

  modport master (
    output sel_valid,
    output sel_off,
    output sel_ch,
    input  sel_ready
  );

  modport slave (
    input  sel_valid,
    input  sel_off,
    input  sel_ch,
    output sel_ready
  );
endinterface

// File: rtl/analog_mux_sequencer.sv
// analog_mux_sequencer: break-before-make controller for a bank of N_CH
// analog pass-gate mux switches sharing one pad bus. Supports host-selected
// connection and an automatic round-robin scan with programmable dwell.
// Optional channel mask: define AMUX_CHAN_MASK_EN to add the ch_mask input
// (masked channels are skipped by the scan and rejected for host requests).
module analog_mux_sequencer #(
  parameter  int unsigned N_CH        = 4,
  parameter  int unsigned DEAD_CYCLES = 2,
  parameter  int unsigned DWELL_W     = 8,
  localparam int unsigned CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  analog_mux_sequencer_if.slave    sel,
  input  logic                     scan_en,
  input  logic [DWELL_W-1:0]       dwell,
`ifdef AMUX_CHAN_MASK_EN
  input  logic [N_CH-1:0]          ch_mask,
`endif
  output logic [N_CH-1:0]          mux_ctrl,
  output logic [CH_W-1:0]          active_ch,
  output logic                     connected,
  output logic                     busy,
  output logic                     err
);

  localparam int unsigned DEAD_W = $clog2(DEAD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BREAK, CONN} state_t;

  state_t               state, state_n;
  logic [CH_W-1:0]      active_n;
  logic [DEAD_W-1:0]    dead_cnt, dead_n;
  logic [DWELL_W-1:0]   dwell_cnt, dwell_n;
  logic [DWELL_W-1:0]   dwell_load;
  logic                 err_n;
  logic                 accept;
  logic                 bad_ch;
  logic [N_CH-1:0]      mask;
  logic [CH_W-1:0]      adv_ch;
  logic                 adv_found;

`ifdef AMUX_CHAN_MASK_EN
  assign mask = ch_mask;
`else
  assign mask = '1;
`endif

  // Channel index base+ofs wrapped into 0..N_CH-1 (base < N_CH, ofs <= N_CH).
  function automatic logic [CH_W-1:0] wrap_ch(input logic [CH_W-1:0] base,
                                              input int unsigned   ofs);
    int unsigned s;
    s = 32'(base) + ofs;
    if (s >= N_CH) s = s - N_CH;
    return CH_W'(s);
  endfunction

  assign sel.sel_ready = ena && (state != BREAK);
  assign accept        = sel.sel_valid && sel.sel_ready;

  // dwell of 0 behaves as 1; counter holds remaining cycles minus one.
  assign dwell_load = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  // Reject out-of-range or masked-off host channels.
  always_comb begin
    bad_ch = 1'b0;
    if (32'(sel.sel_ch) >= N_CH) bad_ch = 1'b1;
    else if (!mask[sel.sel_ch])  bad_ch = 1'b1;
  end

  // Next eligible channel after active_ch, wrapping round.
  always_comb begin
    adv_ch    = active_ch;
    adv_found = 1'b0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      if (!adv_found && mask[wrap_ch(active_ch, i)]) begin
        adv_found = 1'b1;
        adv_ch    = wrap_ch(active_ch, i);
      end
    end
  end

  // Next-state: enable, host request (wins over scan), then break/scan timing.
  always_comb begin
    state_n  = state;
    active_n = active_ch;
    dead_n   = dead_cnt;
    dwell_n  = dwell_cnt;
    err_n    = 1'b0;

    if (!ena) begin
      state_n = IDLE;
      dead_n  = '0;
      dwell_n = '0;
    end else if (accept && sel.sel_off) begin
      state_n = IDLE;
      dwell_n = '0;
    end else if (accept && !bad_ch) begin
      if (state == CONN && sel.sel_ch == active_ch) begin
        dwell_n = dwell_load;
      end else begin
        state_n  = BREAK;
        active_n = sel.sel_ch;
        dead_n   = DEAD_W'(DEAD_CYCLES - 1);
        dwell_n  = '0;
      end
    end else begin
      // A rejected request only flags err; scan timing continues underneath.
      err_n = accept;
      case (state)
        BREAK: begin
          if (dead_cnt == '0) begin
            state_n = CONN;
            dwell_n = dwell_load;
          end else begin
            dead_n = dead_cnt - DEAD_W'(1);
          end
        end
        CONN: begin
          if (!scan_en) begin
            dwell_n = '0;
          end else if (mask == '0) begin
            state_n = IDLE;
          end else if (dwell_cnt == '0) begin
            state_n  = BREAK;
            active_n = adv_ch;
            dead_n   = DEAD_W'(DEAD_CYCLES - 1);
          end else begin
            dwell_n = dwell_cnt - DWELL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State, counters and registered switch controls/status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      active_ch <= '0;
      dead_cnt  <= '0;
      dwell_cnt <= '0;
      mux_ctrl  <= '0;
      connected <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      active_ch <= active_n;
      dead_cnt  <= dead_n;
      dwell_cnt <= dwell_n;
      mux_ctrl  <= (state_n == CONN) ? (N_CH'(1) << active_n) : '0;
      connected <= (state_n == CONN);
      busy      <= (state_n == BREAK);
      err       <= err_n;
    end
  end

`ifndef SYNTHESIS
  logic [N_CH-1:0] last_on;
  int unsigned     zero_run;

  // Track the last closed switch and the length of the all-open run since.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_on  <= '0;
      zero_run <= 0;
    end else if (mux_ctrl != '0) begin
      last_on  <= mux_ctrl;
      zero_run <= 0;
    end else if (zero_run < DEAD_CYCLES) begin
      zero_run <= zero_run + 1;
    end
  end

  // At most one switch closed; switching between channels needs a full break.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(mux_ctrl));
      if (mux_ctrl != '0 && last_on != '0 && mux_ctrl != last_on)
        assert (zero_run >= DEAD_CYCLES);
    end
  end
`endif

endmodule
